// File: rtl/calculation_unit_fraction_normalizer.sv
// ============================================================================
//  Module   : calculation_unit_fraction_normalizer
//  Function : two-stage leading-one normalizer with denormal clamp and
//             valid/ready backpressure; CALC_UNIT_NORMALIZER_STICKY_EN keeps
//             the carry shift-out bit as a sticky bit in fraction bit 0.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module calculation_unit_fraction_normalizer #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [48:0]          in_fraction,
  input  logic [9:0]           in_exponent,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [48:0]          out_fraction,
  output logic [9:0]           out_exponent,
  output logic                 out_zero,
  output logic                 out_overflow,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic                 r_s1_valid;
  logic [48:0]          r_s1_frac;
  logic [9:0]           r_s1_exp;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic [5:0]           r_s1_lzc;

  logic                 r_s2_valid;
  logic [48:0]          r_s2_frac;
  logic [9:0]           r_s2_exp;
  logic                 r_s2_zero;
  logic                 r_s2_ovf;
  logic [TAG_WIDTH-1:0] r_s2_tag;

  logic [5:0]  w_lzc;
  logic        w_s2_free;
  logic        w_s1_advance;
  logic [9:0]  w_want;
  logic [9:0]  w_limit;
  logic [9:0]  w_shift;
  logic [48:0] w_frac;
  logic [9:0]  w_exp;
  logic        w_zero;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_lzc = 6'd49;
    for (int i = 0; i <= 48; i++) begin
      if (in_fraction[i]) w_lzc = 6'(48 - i);
    end
  end

  assign w_s2_free    = !r_s2_valid || out_ready;
  assign w_s1_advance = r_s1_valid && w_s2_free;
  assign in_ready     = !r_s1_valid || w_s1_advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_frac  <= '0;
      r_s1_exp   <= '0;
      r_s1_tag   <= '0;
      r_s1_lzc   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_frac <= in_fraction;
        r_s1_exp  <= in_exponent;
        r_s1_tag  <= in_tag;
        r_s1_lzc  <= w_lzc;
      end
    end
  end

  // Left shift is limited so the exponent never drops below 0.
  always_comb begin
    w_want  = {4'd0, r_s1_lzc} - 10'd1;
    w_limit = ($signed(r_s1_exp) > 10'sd0) ? (r_s1_exp - 10'd1) : 10'd0;
    w_shift = (w_want < w_limit) ? w_want : w_limit;
    w_frac  = r_s1_frac;
    w_exp   = r_s1_exp;
    w_zero  = 1'b0;
    if (r_s1_frac == 49'd0) begin
      w_frac = '0;
      w_exp  = '0;
      w_zero = 1'b1;
    end else if (r_s1_frac[48]) begin
      w_frac = {1'b0, r_s1_frac[48:1]};
`ifdef CALC_UNIT_NORMALIZER_STICKY_EN
      w_frac[0] = r_s1_frac[1] | r_s1_frac[0];
`endif
      w_exp  = r_s1_exp + 10'd1;
    end else if (r_s1_lzc != 6'd1) begin
      w_frac = r_s1_frac << w_shift;
      w_exp  = (w_shift < w_want) ? 10'd0 : (r_s1_exp - w_shift);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_frac  <= '0;
      r_s2_exp   <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_tag   <= '0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_frac <= w_frac;
        r_s2_exp  <= w_exp;
        r_s2_zero <= w_zero;
        r_s2_ovf  <= ($signed(w_exp) >= 10'sd255);
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_fraction = r_s2_frac;
  assign out_exponent = r_s2_exp;
  assign out_zero     = r_s2_zero;
  assign out_overflow = r_s2_ovf;
  assign out_tag      = r_s2_tag;

endmodule

`default_nettype wire

// File: tb/tb_calculation_unit_fraction_normalizer.sv
// Bench for calculation_unit_fraction_normalizer: scoreboard against a
// leading-one-position model plus literal expectations from hand analysis.
`default_nettype none

module tb_calculation_unit_fraction_normalizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [48:0] in_fraction;
  logic [9:0]  in_exponent;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [48:0] out_fraction;
  logic [9:0]  out_exponent;
  logic        out_zero;
  logic        out_overflow;
  logic [3:0]  out_tag;

  calculation_unit_fraction_normalizer #(.TAG_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fraction(in_fraction), .in_exponent(in_exponent), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fraction(out_fraction), .out_exponent(out_exponent),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [48:0] f;
    logic [9:0]  e;
    logic        z;
    logic        o;
    logic [3:0]  t;
  } res_t;

  res_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Model in terms of the leading-one position p (bit 47 is the target).
  function automatic res_t model(input logic [48:0] f, input logic [9:0] e, input logic [3:0] t);
    res_t r;
    int p = -1;
    int ei = int'($signed(e));
    int want, lim, sh, ee;
    for (int i = 0; i < 49; i++) if (f[i]) p = i;
    r.t = t;
    r.z = 1'b0;
    if (p < 0) begin
      r.f = '0; ee = 0; r.z = 1'b1;
    end else if (p == 48) begin
      r.f = f >> 1;
`ifdef CALC_UNIT_NORMALIZER_STICKY_EN
      if (f[0]) r.f[0] = 1'b1;
`endif
      ee = ei + 1;
    end else if (p == 47) begin
      r.f = f; ee = ei;
    end else begin
      want = 47 - p;
      lim  = (ei - 1 > 0) ? ei - 1 : 0;
      sh   = (want < lim) ? want : lim;
      r.f  = f << sh;
      ee   = (sh < want) ? 0 : ei - sh;
    end
    r.e = 10'(ee);
    r.o = (ee >= 255);
    return r;
  endfunction

  // Compare on every cycle the output is valid; stalls therefore also check stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("sb_fraction", 64'(out_fraction), 64'(q[0].f));
          check("sb_exponent", 64'(out_exponent), 64'(q[0].e));
          check("sb_zero",     64'(out_zero),     64'(q[0].z));
          check("sb_overflow", 64'(out_overflow), 64'(q[0].o));
          check("sb_tag",      64'(out_tag),      64'(q[0].t));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_fraction, in_exponent, in_tag));
    end
  end

  task automatic send(input logic [48:0] f, input logic [9:0] e, input logic [3:0] t);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; in_fraction = f; in_exponent = e; in_tag = t;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  // Single operation into an empty pipeline with out_ready=1; literal results.
  task automatic run_one(input string nm, input logic [48:0] f, input logic [9:0] e, input logic [3:0] t,
                         input logic [48:0] xf, input logic [9:0] xe, input logic xz, input logic xo);
    in_valid = 1'b1; in_fraction = f; in_exponent = e; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_early_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({nm, "_valid"},    64'(out_valid),    64'd1);
    check({nm, "_fraction"}, 64'(out_fraction), 64'(xf));
    check({nm, "_exponent"}, 64'(out_exponent), 64'(xe));
    check({nm, "_zero"},     64'(out_zero),     64'(xz));
    check({nm, "_overflow"}, 64'(out_overflow), 64'(xo));
    check({nm, "_tag"},      64'(out_tag),      64'(t));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  logic [48:0] tf[8];
  logic [9:0]  te[8];
  logic [48:0] sticky_exp;
  int          base;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_fraction = '0; in_exponent = '0; in_tag = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fraction", 64'(out_fraction), 64'd0);
    check("rst_out_exponent", 64'(out_exponent), 64'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_one("normal", 49'h0_4000_0000_0000, 10'd100, 4'h1, 49'h0_8000_0000_0000, 10'd99, 1'b0, 1'b0);
    run_one("carry",  49'h1_0000_0000_0002, 10'd254, 4'h2, 49'h0_8000_0000_0001, 10'd255, 1'b0, 1'b1);
`ifdef CALC_UNIT_NORMALIZER_STICKY_EN
    sticky_exp = 49'h0_8000_0000_0001;
`else
    sticky_exp = 49'h0_8000_0000_0000;
`endif
    run_one("sticky", 49'h1_0000_0000_0001, 10'd100, 4'h3, sticky_exp, 10'd101, 1'b0, 1'b0);
    run_one("zero",   49'h0, 10'd50, 4'h4, 49'h0, 10'd0, 1'b1, 1'b0);
    run_one("clamp",  49'h0_0100_0000_0000, 10'd3, 4'h5, 49'h0_0400_0000_0000, 10'd0, 1'b0, 1'b0);
    run_one("lsb_only", 49'h0_0000_0000_0001, 10'd200, 4'h6, 49'h0_8000_0000_0000, 10'd153, 1'b0, 1'b0);
    run_one("exp0",   49'h0_4000_0000_0000, 10'd0, 4'h7, 49'h0_4000_0000_0000, 10'd0, 1'b0, 1'b0);
    run_one("exact",  49'h0_8000_0000_1234, 10'd254, 4'h8, 49'h0_8000_0000_1234, 10'd254, 1'b0, 1'b0);
    drain();

    // Backpressure: four ops, output stalled for five cycles.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++) send(49'h0_1000_0000_0000 << i, 10'(20 + i), 4'(9 + i));
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_first_tag", 64'(out_tag), 64'd9);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_out_count", 64'(n_out - base), 64'd4);

    // Table of boundary vectors under random backpressure.
    tf[0] = 49'h1_FFFF_FFFF_FFFF; te[0] = 10'd254;
    tf[1] = 49'h0_2000_0000_0000; te[1] = 10'd1;
    tf[2] = 49'h0_2000_0000_0000; te[2] = 10'd2;
    tf[3] = 49'h0_0000_0000_0003; te[3] = 10'd48;
    tf[4] = 49'h0_0000_0000_0003; te[4] = 10'd47;
    tf[5] = 49'h0;                te[5] = 10'd254;
    tf[6] = 49'h0_FFFF_FFFF_FFFF; te[6] = 10'd0;
    tf[7] = 49'h0_0000_8000_0000; te[7] = 10'd17;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(tf[i], te[i], 4'(i));
      end
      begin
        repeat (30) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("tbl_out_count", 64'(n_out - base), 64'd8);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(49'h0_4000_0000_0000, 10'd10, 4'hA);
    send(49'h0_4000_0000_0000, 10'd11, 4'hB);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_fraction", 64'(out_fraction), 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1; out_ready = 1'b1;
    #1 check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    run_one("post_rst", 49'h0_4000_0000_0000, 10'd100, 4'hC, 49'h0_8000_0000_0000, 10'd99, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
